// File: rtl/arm_to_java_decoder.sv
// Reverse translator: recognises the fixed two-word ARM sequences emitted by the
// bytecode translator and recovers the original Java opcode, counting opcodes and drops.
module arm_to_java_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm_valid,
    output logic             arm_ready,
    input  logic [31:0]      arm_word,
    output logic             java_valid,
    input  logic             java_ready,
    output logic [7:0]       java_opcode,
    output logic             err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_FIRST,
        S_SECOND,
        S_OUT
    } state_t;

    state_t           state_q;
    logic [31:0]      first_q;
    logic             java_valid_q;
    logic [7:0]       java_opcode_q;
    logic             err_q;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] err_count_q;

    logic             accept;
    logic             word_is_first;
    logic             pair_hit;
    logic [7:0]       pair_op;
    logic [CNT_W-1:0] op_count_d;
    logic [CNT_W-1:0] err_count_d;

    function automatic logic is_first_word(input logic [31:0] w);
        return (w[31:4] == 28'hE3A0100 && w[3:0] <= 4'd5)
            || (w == 32'hE8BD0002)
            || (w[31:4] == 28'hE591300 && w[3:0] <= 4'd3)
            || (w == 32'hE8BD0006);
    endfunction

    assign arm_ready     = (state_q != S_OUT);
    assign accept        = arm_valid && arm_ready;
    assign word_is_first = is_first_word(arm_word);

    assign op_count_d  = (op_count_q  == '1) ? op_count_q  : op_count_q  + CNT_W'(1);
    assign err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + CNT_W'(1);

    // Does the incoming word complete a legal pair with the latched first word?
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        pair_hit = 1'b0;
        pair_op  = 8'h00;
        if (first_q[31:4] == 28'hE3A0100 && first_q[3:0] <= 4'd5
                && arm_word == 32'hE92D0002) begin
            pair_hit = 1'b1;
            pair_op  = 8'h03 + {4'h0, first_q[3:0]};
        end else if (first_q == 32'hE8BD0002
                && arm_word[31:4] == 28'hE581300 && arm_word[3:0] <= 4'd3) begin
            pair_hit = 1'b1;
            pair_op  = 8'h3B + {4'h0, arm_word[3:0]};
        end else if (first_q[31:4] == 28'hE591300 && first_q[3:0] <= 4'd3
                && arm_word == 32'hE92D0002) begin
            pair_hit = 1'b1;
            pair_op  = 8'h1A + {4'h0, first_q[3:0]};
        end else if (first_q == 32'hE8BD0006 && arm_word == 32'hE0810002) begin
            pair_hit = 1'b1;
            pair_op  = 8'h60;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FIRST;
            // NOTE: the pending first word is an ordinary register, so it is cleared with the rest of the state.
            first_q       <= 32'h0;
            java_valid_q  <= 1'b0;
            java_opcode_q <= 8'h00;
            err_q         <= 1'b0;
            op_count_q    <= '0;
            err_count_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_FIRST: begin
                    if (accept) begin
                        if (word_is_first) begin
                            first_q <= arm_word;
                            state_q <= S_SECOND;
                        end else begin
                            err_q       <= 1'b1;
                            err_count_q <= err_count_d;
                        end
                    end
                end
                S_SECOND: begin
                    if (accept) begin
                        if (pair_hit) begin
                            java_opcode_q <= pair_op;
                            java_valid_q  <= 1'b1;
                            first_q       <= 32'h0;
                            state_q       <= S_OUT;
                        end else begin
                            // Broken pair: resync on a usable first word, otherwise start over.
                            err_q       <= 1'b1;
                            err_count_q <= err_count_d;
                            if (word_is_first) begin
                                first_q <= arm_word;
                            end else begin
                                first_q <= 32'h0;
                                state_q <= S_FIRST;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (java_ready) begin
                        java_valid_q <= 1'b0;
                        op_count_q   <= op_count_d;
                        state_q      <= S_FIRST;
                    end
                end
                default: state_q <= S_FIRST;
            endcase
        end
    end

    assign java_valid  = java_valid_q;
    assign java_opcode = java_opcode_q;
    assign err         = err_q;
    assign op_count    = op_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_arm_to_java_decoder.sv
// Bench for arm_to_java_decoder: table-driven legal pairs, directed corner cases,
// and random traffic scored against a transaction-level model of the pair rules.
module tb_arm_to_java_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sat_hold = 1'b1;
    logic        arm_valid = 1'b0;
    logic [31:0] arm_word = 32'h0;
    logic        java_ready = 1'b1;
    logic        arm_ready, java_valid, err;
    logic [7:0]  java_opcode;
    logic [15:0] op_count, err_count;
    logic        s_arm_ready, s_java_valid, s_err;
    logic [7:0]  s_java_opcode;
    logic [1:0]  s_op_count, s_err_count;

    always #5 clk = ~clk;

    arm_to_java_decoder #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .arm_valid(arm_valid), .arm_ready(arm_ready),
        .arm_word(arm_word), .java_valid(java_valid), .java_ready(java_ready),
        .java_opcode(java_opcode), .err(err), .op_count(op_count), .err_count(err_count)
    );

    // Narrow-counter copy fed the same traffic; held in reset until the saturation test.
    arm_to_java_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset | sat_hold), .arm_valid(arm_valid), .arm_ready(s_arm_ready),
        .arm_word(arm_word), .java_valid(s_java_valid), .java_ready(java_ready),
        .java_opcode(s_java_opcode), .err(s_err), .op_count(s_op_count), .err_count(s_err_count)
    );

    typedef struct {
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  op;
    } vec_t;

    vec_t        vecs[15];
    logic [31:0] near[5] = '{32'hE3A01006, 32'hE5913004, 32'hE5813004, 32'hE8BD0003, 32'hE92D0003};

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: pair table lookup, expected opcode queue, counts.
    bit          pend_v = 0;
    logic [31:0] pend_w = 32'h0;
    logic [7:0]  exp_q[$];
    int          m_err = 0;
    int          m_made = 0;
    int          err_seen = 0;
    bit          prev_hold = 0;
    logic [7:0]  prev_op = 8'h00;

    function automatic bit m_is_first(input logic [31:0] w);
        foreach (vecs[i]) if (vecs[i].w1 == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pair(input logic [31:0] a, input logic [31:0] b);
        foreach (vecs[i]) if (vecs[i].w1 == a && vecs[i].w2 == b) return i;
        return -1;
    endfunction

    task automatic model_word(input logic [31:0] w);
        int idx;
        if (!pend_v) begin
            if (m_is_first(w)) begin
                pend_v = 1'b1;
                pend_w = w;
            end else begin
                m_err++;
            end
        end else begin
            idx = m_pair(pend_w, w);
            if (idx >= 0) begin
                exp_q.push_back(vecs[idx].op);
                m_made++;
                pend_v = 1'b0;
            end else begin
                m_err++;
                if (m_is_first(w)) pend_w = w;
                else pend_v = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            pend_v = 1'b0;
            exp_q.delete();
            m_err = 0;
            m_made = 0;
            err_seen = 0;
            prev_hold = 1'b0;
        end else begin
            if (err) err_seen++;
            if (java_valid) check("arm_ready_low_while_out", arm_ready, 1'b0);
            if (prev_hold) check("held_output", {java_valid, java_opcode}, {1'b1, prev_op});
            if (java_valid && java_ready) begin
                check("err_not_with_delivery", err, 1'b0);
                if (exp_q.size() == 0) check("opcode_was_expected", 32'(exp_q.size()), 1);
                else check("opcode", java_opcode, exp_q.pop_front());
            end
            prev_hold = java_valid && !java_ready;
            prev_op   = java_opcode;
            if (arm_valid && arm_ready) model_word(arm_word);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        arm_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present a word and return #1 after the edge that accepted it.
    task automatic send(input logic [31:0] w);
        int n = 0;
        arm_valid = 1'b1;
        arm_word  = w;
        while (!arm_ready && n < 50) begin
            step();
            n++;
        end
        if (!arm_ready) check("send_timeout", arm_ready, 1'b1);
        step();
        arm_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_word();
        int r = int'($urandom_range(0, 9));
        if (r < 4) return vecs[$urandom_range(0, 14)].w1;
        if (r < 7) return vecs[$urandom_range(0, 14)].w2;
        if (r < 8) return near[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        for (int n = 0; n < 6; n++) vecs[n]      = '{32'(32'hE3A01000 + n), 32'hE92D0002, 8'(8'h03 + n)};
        for (int k = 0; k < 4; k++) vecs[6 + k]  = '{32'hE8BD0002, 32'(32'hE5813000 + k), 8'(8'h3B + k)};
        for (int k = 0; k < 4; k++) vecs[10 + k] = '{32'(32'hE5913000 + k), 32'hE92D0002, 8'(8'h1A + k)};
        vecs[14] = '{32'hE8BD0006, 32'hE0810002, 8'h60};

        // Reset values.
        do_reset();
        check("rst_java_valid", java_valid, 1'b0);
        check("rst_java_opcode", java_opcode, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_op_count", op_count, 16'd0);
        check("rst_err_count", err_count, 16'd0);
        check("rst_arm_ready", arm_ready, 1'b1);

        // iconst_3 back-to-back.
        send(32'hE3A01003);
        check("iconst3_not_early", java_valid, 1'b0);
        send(32'hE92D0002);
        check("iconst3_valid", java_valid, 1'b1);
        check("iconst3_opcode", java_opcode, 8'h06);
        step();
        check("iconst3_op_count", op_count, 16'd1);
        check("iconst3_no_err", 32'(err_seen), 0);

        // All 15 legal pairs in order.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].w1);
            send(vecs[i].w2);
            check("table_valid", java_valid, 1'b1);
            check("table_opcode", java_opcode, vecs[i].op);
        end
        step();
        check("table_op_count", op_count, 16'd15);
        check("table_err_count", err_count, 16'd0);

        // Backpressure on a completed iadd.
        java_ready = 1'b0;
        send(32'hE8BD0006);
        send(32'hE0810002);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", java_valid, 1'b1);
            check("stall_opcode", java_opcode, 8'h60);
            check("stall_arm_ready", arm_ready, 1'b0);
            step();
        end
        java_ready = 1'b1;
        step();
        check("stall_release_valid", java_valid, 1'b0);
        check("stall_release_ready", arm_ready, 1'b1);
        check("stall_release_count", op_count, 16'd16);
        check("stall_release_opcode_held", java_opcode, 8'h60);

        // Error paths.
        do_reset();
        send(32'hE92D0002);
        check("bad_first_err", err, 1'b1);
        check("bad_first_err_count", err_count, 16'd1);
        check("bad_first_ready", arm_ready, 1'b1);
        step();
        check("bad_first_err_pulse_ends", err, 1'b0);
        send(32'hE8BD0002);
        check("resync_first_no_err", err, 1'b0);
        send(32'hE5913002);
        check("resync_err", err, 1'b1);
        check("resync_err_count", err_count, 16'd2);
        send(32'hE92D0002);
        check("resync_valid", java_valid, 1'b1);
        check("resync_opcode", java_opcode, 8'h1C);
        check("resync_err_count_final", err_count, 16'd2);
        step();

        // Reset while an istore_2 opcode is pending.
        java_ready = 1'b0;
        send(32'hE8BD0002);
        send(32'hE5813002);
        check("pend_valid", java_valid, 1'b1);
        check("pend_opcode", java_opcode, 8'h3D);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", java_valid, 1'b0);
        check("midrst_op_count", op_count, 16'd0);
        check("midrst_err_count", err_count, 16'd0);
        check("midrst_ready", arm_ready, 1'b1);
        java_ready = 1'b1;
        send(32'hE8BD0006);
        send(32'hE0810002);
        check("midrst_after_opcode", java_opcode, 8'h60);
        step();
        check("midrst_after_count", op_count, 16'd1);

        // Saturation with a 2-bit counter copy.
        sat_hold = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(32'hE92D0002);
            send(vecs[i * 3].w1);
            send(vecs[i * 3].w2);
            step();
            if (i == 2) begin
                check("sat_op_reach", s_op_count, 2'd3);
                check("sat_err_reach", s_err_count, 2'd3);
            end
        end
        check("sat_op_held", s_op_count, 2'd3);
        check("sat_err_held", s_err_count, 2'd3);
        check("wide_op_count", op_count, 16'd5);
        check("wide_err_count", err_count, 16'd5);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            arm_valid  = ($urandom_range(0, 3) != 0);
            arm_word   = pick_word();
            java_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        arm_valid  = 1'b0;
        java_ready = 1'b1;
        begin
            int n = 0;
            while ((exp_q.size() != 0 || java_valid) && n < 200) begin
                step();
                n++;
            end
        end
        step();
        check("rand_drained", 32'(exp_q.size()), 0);
        check("rand_op_count", op_count, 16'(m_made));
        check("rand_err_count", err_count, 16'(m_err));
        check("rand_err_pulses", 32'(err_seen), 32'(m_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
